// File: rtl/pool_unit.sv
// Pipelined mean/max pooling tree: L = log2(NH_SIZE) tree stages plus one output register, latency L+1.
// Backpressure: one global advance (!out_valid | out_ready) freezes every stage; in_ready equals that advance.
module pool_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int NH_SIZE    = 4,
   parameter int ROUND      = 0
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_mode,
   input  logic [NH_SIZE*DATA_WIDTH-1:0] in_vector,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_mode
);

   localparam int L     = $clog2(NH_SIZE);
   localparam int SW    = DATA_WIDTH + L;
   localparam int NODES = NH_SIZE - 1;

   // Stage k occupies a contiguous slice of the node array starting here.
   function automatic int off(input int k);
      return NH_SIZE - (NH_SIZE >> (k - 1));
   endfunction

   logic [NODES-1:0][SW-1:0] node_q;
   logic [NODES-1:0][SW-1:0] node_d;
   logic [L:1]               vld_q;
   logic [L:1]               mode_q;
   logic                     out_valid_q;
   logic                     out_mode_q;
   logic [DATA_WIDTH-1:0]    out_data_q;
   logic [DATA_WIDTH-1:0]    out_data_d;
   logic [DATA_WIDTH-1:0]    mean_res;
   logic [SW-1:0]            root;
   logic                     adv;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_mode  = out_mode_q;

   genvar k, j;
   for (k = 1; k <= L; k++) begin : g_stage
      for (j = 0; j < (NH_SIZE >> k); j++) begin : g_node
         logic [SW-1:0] a;
         logic [SW-1:0] b;
         logic          m;
         if (k == 1) begin : g_leaf
            assign a = SW'(in_vector[(2*j)*DATA_WIDTH +: DATA_WIDTH]);
            assign b = SW'(in_vector[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]);
            assign m = in_mode;
         end else begin : g_inner
            assign a = node_q[off(k-1) + 2*j];
            assign b = node_q[off(k-1) + 2*j + 1];
            assign m = mode_q[k-1];
         end
         assign node_d[off(k) + j] = m ? ((a > b) ? a : b) : (a + b);
      end
   end

   assign root = node_q[NODES-1];

   if (ROUND != 0) begin : g_round
      logic [SW:0]         rnd_sum;
      logic [DATA_WIDTH:0] rnd_shift;
      assign rnd_sum   = {1'b0, root} + ((SW+1)'(1) << (L - 1));
      assign rnd_shift = (DATA_WIDTH+1)'(rnd_sum >> L);
      // Unreachable for legal inputs, but never let the mean wrap to a small value.
      assign mean_res  = rnd_shift[DATA_WIDTH] ? '1 : rnd_shift[DATA_WIDTH-1:0];
   end else begin : g_trunc
      assign mean_res = DATA_WIDTH'(root >> L);
   end

   assign out_data_d = mode_q[L] ? root[DATA_WIDTH-1:0] : mean_res;

   // Data registers carry no reset: their contents are ignored while the matching valid bit is low.
   always_ff @(posedge clock) begin
      if (adv) begin
         node_q <= node_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q       <= '0;
         mode_q      <= '0;
         out_valid_q <= 1'b0;
         out_mode_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (adv) begin
         vld_q[1]  <= in_valid;
         mode_q[1] <= in_mode;
         for (int s = 2; s <= L; s++) begin
            vld_q[s]  <= vld_q[s-1];
            mode_q[s] <= mode_q[s-1];
         end
         out_valid_q <= vld_q[L];
         out_mode_q  <= mode_q[L];
         out_data_q  <= out_data_d;
      end
   end

endmodule
